// File: rtl/sram_ctrl_pkg.sv
// Shared types and default timings for the SRAM read/write sequencer.
// Holds the FSM state set, the request bundle and sizing helpers.
package sram_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    PRE,
    RPULSE,
    SENSE,
    CAPT,
    RESP,
    GAP
  } state_t;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 4;
  localparam int DEF_WR_CYC  = 10;
  localparam int DEF_PRE_CYC = 2;
  localparam int DEF_RD_CYC  = 10;
  localparam int DEF_GAP_CYC = 10;
  localparam int DEF_AW      = 2;

  // Request bundle at the default array geometry.
  typedef struct packed {
    logic                we;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_COLS-1:0] wdata;
  } req_t;

  function automatic int max_of(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  // Width of a counter that must reach m-1.
  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_rw_ctrl_row_decoder.sv
// One-hot row decoder with enable for the SRAM wordlines.
// Ports: addr (row index), en (gate), row (one-hot, zero if out of range).
module row_decoder
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = DEF_AW
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [ROWS-1:0] row
);

  always_comb begin
    row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (en && (addr == AW'(i))) begin
        row[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rw_ctrl.sv
// Read/write sequencer for the mixed-signal SRAM array: wordline,
// bitline, precharge and sense-amp timing behind a valid/ready port.
// Ports: clk, rst (async, active high); req_valid/ready/we/addr/wdata;
// rsp_valid/rdata/err; row_wr, row_rd, bl_drv_en, bl_data, pre_en,
// sa_en (to array); sa_out (from sense amps).
// Option: SRAM_RW_CTRL_WRITE_VERIFY_EN adds a read-back after writes.
module sram_rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int WR_CYC  = DEF_WR_CYC,
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int RD_CYC  = DEF_RD_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  output logic            bl_drv_en,
  output logic [COLS-1:0] bl_data,
  output logic            pre_en,
  output logic            sa_en,
  input  logic [COLS-1:0] sa_out
);

  localparam int CMAX = max_of(max_of(WR_CYC, PRE_CYC),
                               max_of(RD_CYC, GAP_CYC));
  localparam int CW = cnt_w(CMAX);

  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [AW:0]   ROWS_W   = (AW + 1)'(ROWS);

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [AW-1:0]   q_addr;
  logic [COLS-1:0] q_wdata;
  logic [COLS-1:0] wd_nxt;
  logic            err_q;
  logic            err_nxt;
  logic            oor;
  logic            dec_en;
  logic            drv_nxt;
  logic [ROWS-1:0] dec;

`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
  logic q_we;
`endif

  assign oor    = {1'b0, req_addr} >= ROWS_W;
  assign dec_en = (nxt == WPULSE) | (nxt == RPULSE)
                | (nxt == SENSE);
  assign drv_nxt = (nxt == WSETUP) | (nxt == WPULSE)
                 | (nxt == WHOLD);
  // Data is driven from the accept edge, before q_wdata is loaded.
  assign wd_nxt = (state == IDLE) ? req_wdata : q_wdata;

  row_decoder #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_dec (
    .addr (q_addr),
    .en   (dec_en),
    .row  (dec)
  );

  always_comb begin
    nxt     = state;
    err_nxt = err_q;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          err_nxt = oor;
          if (oor) nxt = RESP;
          else     nxt = req_we ? WSETUP : PRE;
        end
      end
      WSETUP: nxt = WPULSE;
      WPULSE: if (cnt == WR_LAST) nxt = WHOLD;
`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
      WHOLD:  nxt = PRE;
`else
      WHOLD:  nxt = RESP;
`endif
      PRE:    if (cnt == PRE_LAST) nxt = RPULSE;
      RPULSE: if (cnt == RD_LAST) nxt = SENSE;
      SENSE:  nxt = CAPT;
      CAPT: begin
        nxt = RESP;
`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
        if (q_we) err_nxt = (sa_out != q_wdata);
`endif
      end
      RESP:   nxt = (GAP_CYC > 0) ? GAP : IDLE;
      GAP:    if (cnt == GAP_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Count cycles spent in the current state; idle holds at zero.
    if (nxt != state || state == IDLE) cnt_nxt = '0;
    else                               cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q_addr    <= '0;
      q_wdata   <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      row_wr    <= '0;
      row_rd    <= '0;
      bl_drv_en <= 1'b0;
      bl_data   <= '0;
      pre_en    <= 1'b0;
      sa_en     <= 1'b0;
`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
      q_we      <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (state == IDLE && req_valid) begin
        q_addr  <= req_addr;
        q_wdata <= req_wdata;
`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
        q_we    <= req_we;
`endif
      end
      if (state == CAPT) rsp_rdata <= sa_out;
      req_ready <= (nxt == IDLE);
      rsp_valid <= (nxt == RESP);
      rsp_err   <= (nxt == RESP) && err_nxt;
      row_wr    <= (nxt == WPULSE) ? dec : '0;
      row_rd    <= (nxt == RPULSE || nxt == SENSE)
                   ? dec : '0;
      bl_drv_en <= drv_nxt;
      bl_data   <= drv_nxt ? wd_nxt : '0;
      pre_en    <= (nxt == PRE);
      sa_en     <= (nxt == SENSE);
    end
  end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Self-checking bench for sram_rw_ctrl: vector table, random traffic
// against an array model, plus reset, back-to-back and range cases.
module tb_sram_rw_ctrl;
  import sram_ctrl_pkg::*;

  localparam int T_WR  = 10;
  localparam int T_PRE = 2;
  localparam int T_RD  = 10;
  localparam int T_GAP = 10;
`ifdef SRAM_RW_CTRL_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int WLAT = VER ? T_WR + T_PRE + T_RD + 5 : T_WR + 3;
  localparam int RLAT = T_PRE + T_RD + 3;

  localparam int G2_WR  = 2;
  localparam int G2_PRE = 1;
  localparam int G2_RD  = 1;
  localparam int G2_GAP = 3;

  typedef struct {
    req_t       req;
    logic [3:0] flip;
    int         lat;
    logic       err;
    logic [3:0] rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] row_wr;
  logic [3:0] row_rd;
  logic       bl_drv_en;
  logic [3:0] bl_data;
  logic       pre_en;
  logic       sa_en;
  logic [3:0] sa_out = '0;

  logic       req_valid2 = 1'b0;
  logic       req_ready2;
  logic       req_we2 = 1'b0;
  logic [1:0] req_addr2 = '0;
  logic [3:0] req_wdata2 = '0;
  logic       rsp_valid2;
  logic [3:0] rsp_rdata2;
  logic       rsp_err2;
  logic [2:0] row_wr2;
  logic [2:0] row_rd2;
  logic       bl_drv_en2;
  logic [3:0] bl_data2;
  logic       pre_en2;
  logic       sa_en2;
  logic [3:0] sa2 = 4'b1001;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] mem [4]     = '{default: '0};
  logic [3:0] ref_mem [4] = '{default: '0};
  logic [3:0] flip    = '0;
  logic [3:0] last_rd = '0;
  logic [1:0] cur_addr  = '0;
  logic [3:0] cur_wdata = '0;
  bit         mon_en    = 1'b0;

  always #5 clk = ~clk;

  sram_rw_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .row_wr    (row_wr),
    .row_rd    (row_rd),
    .bl_drv_en (bl_drv_en),
    .bl_data   (bl_data),
    .pre_en    (pre_en),
    .sa_en     (sa_en),
    .sa_out    (sa_out)
  );

  sram_rw_ctrl #(
    .ROWS    (3),
    .COLS    (4),
    .WR_CYC  (G2_WR),
    .PRE_CYC (G2_PRE),
    .RD_CYC  (G2_RD),
    .GAP_CYC (G2_GAP)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_we    (req_we2),
    .req_addr  (req_addr2),
    .req_wdata (req_wdata2),
    .rsp_valid (rsp_valid2),
    .rsp_rdata (rsp_rdata2),
    .rsp_err   (rsp_err2),
    .row_wr    (row_wr2),
    .row_rd    (row_rd2),
    .bl_drv_en (bl_drv_en2),
    .bl_data   (bl_data2),
    .pre_en    (pre_en2),
    .sa_en     (sa_en2),
    .sa_out    (sa2)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx4(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Array and sense-amp model: cells take bl_data while a write
  // wordline is up; sense result appears the cycle after sa_en.
  always @(posedge clk) begin
    if (bl_drv_en && row_wr != 0) mem[idx4(row_wr)] <= bl_data;
    if (sa_en) sa_out <= mem[idx4(row_rd)] ^ flip;
  end

  int         wr_run = 0;
  int         rd_run = 0;
  int         pre_run = 0;
  int         sa_pos = 0;
  logic       prev_drv = 1'b0;
  logic [3:0] prev_data = '0;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      wr_run = 0; rd_run = 0; pre_run = 0; sa_pos = 0;
    end else begin
      chk("invariants",
          {($countones(row_wr | row_rd) > 1),
           (row_wr != 0 && row_rd != 0),
           (pre_en && row_rd != 0),
           (bl_drv_en && row_rd != 0),
           (sa_en && row_rd == 0)}, 0);
      if (row_wr != 0) begin
        if (wr_run == 0)
          chk("drv_before_rise", {prev_drv, prev_data},
              {1'b1, cur_wdata});
        wr_run++;
        chk("wr_row_data", {row_wr, bl_drv_en, bl_data},
            {4'b0001 << cur_addr, 1'b1, cur_wdata});
      end else if (wr_run != 0) begin
        chk("wr_width", wr_run, T_WR);
        chk("drv_after_fall", {bl_drv_en, bl_data},
            {1'b1, cur_wdata});
        wr_run = 0;
      end
      if (pre_en) pre_run++;
      if (row_rd != 0) begin
        if (rd_run == 0) chk("pre_width", pre_run, T_PRE);
        rd_run++;
        chk("rd_row", row_rd, 4'b0001 << cur_addr);
        if (sa_en) sa_pos = rd_run;
      end else if (rd_run != 0) begin
        chk("rd_width", rd_run, T_RD + 1);
        chk("sa_pos", sa_pos, T_RD + 1);
        rd_run = 0; pre_run = 0; sa_pos = 0;
      end
    end
    prev_drv  = bl_drv_en;
    prev_data = bl_data;
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk); n++;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic run_req(
    input  logic       we,
    input  logic [1:0] a,
    input  logic [3:0] wd,
    output int         lat,
    output logic       err,
    output logic [3:0] rd
  );
    wait_ready();
    cur_addr = a; cur_wdata = wd;
    req_valid = 1'b1; req_we = we;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid) lat = -1;
    err = rsp_err;
    rd  = rsp_rdata;
  endtask

  task automatic model(
    input  logic       we,
    input  logic [1:0] a,
    input  logic [3:0] wd,
    output int         lat,
    output logic       err,
    output logic [3:0] rd
  );
    err = 1'b0;
    if (we) begin
      ref_mem[a] = wd;
      lat = WLAT;
      if (VER) begin
        last_rd = wd ^ flip;
        err = (flip != 0);
      end
    end else begin
      lat = RLAT;
      last_rd = ref_mem[a] ^ flip;
    end
    rd = last_rd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [9];
    int         lat, mlat, t, last, nacc, n, k;
    logic       err, merr;
    logic [3:0] rd, mrd;

    tbl[0] = '{'{1'b1, 2'd2, 4'b1011}, 4'h0, WLAT, 1'b0,
               VER ? 4'b1011 : 4'b0000};
    tbl[1] = '{'{1'b0, 2'd2, 4'b0000}, 4'h0, RLAT, 1'b0,
               4'b1011};
    tbl[2] = '{'{1'b1, 2'd0, 4'b0110}, 4'h0, WLAT, 1'b0,
               VER ? 4'b0110 : 4'b1011};
    tbl[3] = '{'{1'b0, 2'd0, 4'b0000}, 4'h0, RLAT, 1'b0,
               4'b0110};
    tbl[4] = '{'{1'b0, 2'd3, 4'b0000}, 4'h0, RLAT, 1'b0,
               4'b0000};
    tbl[5] = '{'{1'b1, 2'd1, 4'b0110}, 4'b0010, WLAT, VER,
               VER ? 4'b0100 : 4'b0000};
    tbl[6] = '{'{1'b0, 2'd1, 4'b0000}, 4'h0, RLAT, 1'b0,
               4'b0110};
    tbl[7] = '{'{1'b1, 2'd3, 4'b1111}, 4'h0, WLAT, 1'b0,
               VER ? 4'b1111 : 4'b0110};
    tbl[8] = '{'{1'b0, 2'd3, 4'b0000}, 4'h0, RLAT, 1'b0,
               4'b1111};

    #1 rst = 1'b1;
    #2;
    chk("reset_outs",
        {req_ready, rsp_valid, rsp_err, rsp_rdata, row_wr,
         row_rd, bl_drv_en, bl_data, pre_en, sa_en},
        {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0,
         1'b0, 1'b0});
    chk("reset_ready2", {req_ready2, row_wr2, row_rd2},
        {1'b1, 3'b0, 3'b0});
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      flip = tbl[i].flip;
      run_req(tbl[i].req.we, tbl[i].req.addr, tbl[i].req.wdata,
              lat, err, rd);
      model(tbl[i].req.we, tbl[i].req.addr, tbl[i].req.wdata,
            mlat, merr, mrd);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end
    flip = '0;

    // req_valid held: accepts must be spaced by latency + gap + 1.
    wait_ready();
    cur_addr = 2'd2;
    req_we = 1'b0; req_addr = 2'd2; req_valid = 1'b1;
    t = 0; last = -1; nacc = 0;
    while (nacc < 3 && t < 200) begin
      if (rsp_valid) chk("b2b_rdata", rsp_rdata, ref_mem[2]);
      if (req_ready) begin
        if (last >= 0)
          chk("b2b_spacing", t - last, RLAT + T_GAP + 1);
        last = t; nacc++;
      end
      if (nacc < 3) begin
        @(negedge clk); t++;
      end
    end
    chk("b2b_accepts", nacc, 3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk); n++;
    end
    chk("b2b_last_rsp", {rsp_valid, rsp_rdata},
        {1'b1, ref_mem[2]});
    last_rd = ref_mem[2];

    // Reset in the fifth write-wordline cycle.
    wait_ready();
    cur_addr = 2'd1; cur_wdata = 4'b1100;
    req_we = 1'b1; req_addr = 2'd1;
    req_wdata = 4'b1100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; k = 0;
    while (n < 5 && k < 50) begin
      if (row_wr != 0) n++;
      if (n < 5) begin
        @(negedge clk); k++;
      end
    end
    chk("rst_pulse_cycle", n, 5);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs",
        {row_wr, bl_drv_en, pre_en, sa_en, rsp_valid,
         req_ready, rsp_rdata},
        {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0});
    @(negedge clk);
    rst = 1'b0;
    ref_mem[1] = 4'b1100;
    last_rd = '0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_no_rsp", n, 0);
    chk("rst_ready", req_ready, 1);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      logic       rwe;
      logic [1:0] ra;
      logic [3:0] rw;
      rwe = 1'($urandom_range(0, 1));
      ra  = 2'($urandom_range(0, 3));
      rw  = 4'($urandom);
      model(rwe, ra, rw, mlat, merr, mrd);
      run_req(rwe, ra, rw, lat, err, rd);
      chk($sformatf("rnd%0d_lat", i), lat, mlat);
      chk($sformatf("rnd%0d_err", i), err, merr);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
    end

    // Three-row instance: valid read, then out-of-range read.
    req_addr2 = 2'd0; req_we2 = 1'b0; req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    lat = 1;
    while (!rsp_valid2 && lat < 50) begin
      @(negedge clk); lat++;
    end
    chk("r3_read_lat", lat, G2_PRE + G2_RD + 3);
    chk("r3_read_rsp", {rsp_err2, rsp_rdata2}, {1'b0, 4'b1001});
    n = 0;
    while (!req_ready2 && n < 50) begin
      @(negedge clk); n++;
    end
    req_addr2 = 2'd3; req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    k = 0; lat = 1;
    while (!rsp_valid2 && lat < 50) begin
      if ((row_wr2 | row_rd2) != 0) k++;
      @(negedge clk); lat++;
    end
    chk("r3_oor_lat", lat, 1);
    chk("r3_oor_rsp", {rsp_err2, rsp_rdata2}, {1'b1, 4'b1001});
    n = 0;
    while (!req_ready2 && n < 50) begin
      if ((row_wr2 | row_rd2) != 0) k++;
      @(negedge clk); n++;
    end
    chk("r3_oor_no_wl", k, 0);
    chk("r3_ready_back", n, G2_GAP + 1);

    // Top row of the three-row instance.
    req_addr2 = 2'd2; req_we2 = 1'b1;
    req_wdata2 = 4'b0101; req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
    k = 0; lat = 1;
    while (!rsp_valid2 && lat < 50) begin
      if (row_wr2 == 3'b100) k++;
      @(negedge clk); lat++;
    end
    chk("r3_wr_width", k, G2_WR);
    chk("r3_wr_lat", lat,
        VER ? G2_WR + G2_PRE + G2_RD + 5 : G2_WR + 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rw_ctrl.md
Name: sram_rw_ctrl

Overview:
- Digital sequencer for the mixed-signal SRAM cell array.
- Accepts one read or write request at a time on a valid/ready interface.
- Decodes the row address into one-hot write or read wordline pulses, drives write-bitline data and enables, and times precharge and sense-amp enable.
- Captures sense-amp outputs and returns read data. Real-valued bitline conversion lives in the analog wrapper, outside this block.

Parameters:
- ROWS, 4, number of array rows; must be ≥1.
- COLS, 4, number of array columns (word width).
- WR_CYC, 10, cycles row_wr is held high; must be ≥1.
- PRE_CYC, 2, cycles of read-bitline precharge before row_rd; must be ≥1.
- RD_CYC, 10, cycles row_rd is held high before sensing; must be ≥1.
- GAP_CYC, 10, idle cycles with all wordlines low after every operation; 0 allowed.
- AW, $clog2(ROWS) (minimum 1), address width; derived, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  row address
- req_wdata  in  COLS  write data
- rsp_valid  out  1  one-cycle pulse: read data valid, or write complete
- rsp_rdata  out  COLS  captured read data
- rsp_err  out  1  qualifies rsp_valid: address out of range, or verify failure
- row_wr  out  ROWS  one-hot write wordlines
- row_rd  out  ROWS  one-hot read wordlines
- bl_drv_en  out  1  drive bl_wr/blb_wr; otherwise bitlines float
- bl_data  out  COLS  per column: 1 → bl_wr=VDD, blb_wr=VSS; 0 → the complement
- pre_en  out  1  precharge bl_rd/blb_rd
- sa_en  out  1  sense-amp strobe
- sa_out  in  COLS  sense-amp digital result; valid the cycle after sa_en

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release): state IDLE; counters cleared.
  - All outputs 0 except req_ready=1.
  - rsp_rdata=0.
  - Reset mid-operation drops every wordline in the same cycle, aborts the operation and emits no response.
- Handshake: a request is accepted on req_valid & req_ready. req_ready=1 only in IDLE. Request fields are latched at acceptance.
- Out-of-range address (req_addr ≥ ROWS): no wordline is asserted. Path is IDLE → RESP with rsp_err=1. rsp_rdata holds its previous value.
- States and transitions:
  - IDLE → WSETUP on an accepted write; IDLE → PRE on an accepted read.
  - WSETUP (1 cycle): bl_drv_en=1; bl_data=latched wdata; no wordline.
  - WPULSE (WR_CYC cycles): bl_drv_en=1; row_wr[addr]=1.
  - WHOLD (1 cycle): row_wr=0; bl_drv_en stays 1, so data is held past the wordline fall. Then → RESP.
  - PRE (PRE_CYC cycles): pre_en=1.
  - RPULSE (RD_CYC cycles): pre_en=0; row_rd[addr]=1.
  - SENSE (1 cycle): row_rd stays high; sa_en=1.
  - CAPT (1 cycle): row_rd=0; rsp_rdata ← sa_out. Then → RESP.
  - RESP (1 cycle): rsp_valid=1. Then → GAP if GAP_CYC>0, else → IDLE.
  - GAP (GAP_CYC cycles): all wordlines low. Then → IDLE.
- Invariants:
  - At most one bit is set across row_wr|row_rd.
  - row_wr and row_rd are never both nonzero.
  - pre_en and any row_rd bit are never both high.
  - bl_drv_en=0 whenever row_rd≠0.
- Latency, accept cycle to rsp_valid:
  - write = WR_CYC+3
  - read = PRE_CYC+RD_CYC+3
  - out-of-range = 1
- Back-to-back requests: the next accept occurs GAP_CYC+1 cycles after rsp_valid. req_valid held during busy states is ignored, not queued.
- Counters are wide enough for max(WR_CYC, PRE_CYC, RD_CYC, GAP_CYC). The terminal count triggers the state transition; no wrap.

Optional Feature:
- SRAM_RW_CTRL_WRITE_VERIFY_EN.
- Defined: after WHOLD, the controller runs PRE→RPULSE→SENSE→CAPT on the same row, then compares sa_out with the latched wdata.
  - rsp_err=1 on mismatch.
  - rsp_rdata holds the read-back value.
  - Write latency becomes WR_CYC+PRE_CYC+RD_CYC+5.
- Undefined: write goes WHOLD→RESP directly, and rsp_err is used only for out-of-range addresses.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum: IDLE, WSETUP, WPULSE, WHOLD, PRE, RPULSE, SENSE, CAPT, RESP, GAP.
  - typedef for the request struct: we, addr, wdata.
  - localparam default timings.
- One sub-module, row_decoder: combinational AW→ROWS one-hot decoder with enable. It is instantiated once; its output is steered to row_wr or row_rd by state.

Test Plan:
- Defaults; write addr=2, wdata=4'b1011 → row_wr=4'b0100 for exactly 10 cycles; bl_data=1011 with bl_drv_en high from 1 cycle before rise to 1 cycle after fall; rsp_valid at accept+13, rsp_err=0.
- Read addr=2, model returns sa_out=1011 → pre_en 2 cycles, then row_rd=4'b0100 for 11 cycles, sa_en in the last of them; rsp_valid at accept+15, rsp_rdata=1011.
- ROWS=3, read addr=3 → no wordline ever asserts; rsp_valid and rsp_err one cycle after accept; req_ready returns after GAP_CYC.
- req_valid held high continuously → accepts spaced by latency+GAP_CYC+1; req_ready=0 throughout each operation; wordline one-hot invariant holds every cycle.
- rst asserted during WPULSE cycle 5 → row_wr=0 and bl_drv_en=0 immediately (asynchronously); no rsp_valid; req_ready=1 after release.
- SRAM_RW_CTRL_WRITE_VERIFY_EN defined, write 0110, model reads back 0100 → rsp_err=1, rsp_rdata=0100, rsp_valid at accept+27.
